round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round initiator that drives the answer-period timer. Each round it latches a
//  target symbol count, pulses answerSig to open the answer window, and counts player
//  guess presses until the timer returns postSig. It then judges the guess, updates the
//  score and holds the result on display before starting the next round.
//  Runs on Clk100M; all second-scale timing comes from the one-cycle tick1Hz strobe.
// PARAMETERS
//  CW            8   width of target, guess and score counters
//  NUM_ROUNDS    5   rounds per game (1..15)
//  SHOW_SECS     2   tick1Hz ticks the result is held in SHOW
//  TIMEOUT_SECS  8   tick1Hz ticks allowed in ANSWER before postSig; must exceed answer period
// PORTS
//  Clk100M        in   1   system clock; all logic is on its rising edge
//  rstN           in   1   synchronous reset, active low
//  tick1Hz        in   1   one-cycle strobe, once per second
//  startBtn       in   1   debounced one-cycle start pulse
//  targetValid    in   1   one-cycle pulse: targetCount is valid
//  targetCount    in   CW  symbol count the player must match
//  playerInc      in   1   debounced one-cycle guess-increment pulse
//  postSig        in   1   one-cycle pulse from answer-period timer: window closed
//  answerSig      out  1   one-cycle pulse: open the answer window
//  busy           out  1   high in every state except IDLE
//  guess          out  CW  current guess count
//  score          out  CW  correct rounds this game
//  roundNum       out  4   current round, 1-based; 0 in IDLE
//  resultValid    out  1   high throughout SHOW
//  resultCorrect  out  1   guess==target for the shown round; valid while resultValid
//  timeoutErr     out  1   sticky: postSig never arrived; cleared by startBtn or reset
// BEHAVIOUR
//  Reset (rstN==0 at a clock edge): state=IDLE, all outputs 0, internal counters 0.
//   This takes effect mid-round too; no answerSig is issued after reset.
//  States: IDLE, WAIT_TGT, ARM, ANSWER, JUDGE, SHOW. All outputs are registered.
//  IDLE: on startBtn, clear score, guess and timeoutErr; roundNum<=1; go to WAIT_TGT.
//  WAIT_TGT: on targetValid, latch targetCount and clear guess; go to ARM.
//  ARM: exactly one cycle; answerSig=1 in that cycle only; clear the tick counter;
//   go to ANSWER.
//  ANSWER: each playerInc adds 1 to guess, saturating at 2^CW-1.
//   If postSig arrives, go to JUDGE. A playerInc in the same cycle as postSig still counts.
//   Each tick1Hz increments the tick counter.
//   If the counter reaches TIMEOUT_SECS with no postSig: set timeoutErr, roundNum<=0,
//   go to IDLE. postSig wins over a timeout in the same cycle.
//  JUDGE: one cycle. resultCorrect<=(guess==target).
//   If correct, score+=1, saturating at 2^CW-1. Clear the tick counter; go to SHOW.
//  SHOW: resultValid=1. After SHOW_SECS tick1Hz strobes:
//   if roundNum==NUM_ROUNDS, go to IDLE (roundNum<=0; score is kept);
//   otherwise roundNum+=1 and go to WAIT_TGT.
//   resultValid drops when SHOW is left.
//  Ignored inputs: startBtn outside IDLE; targetValid outside WAIT_TGT;
//   playerInc outside ANSWER; postSig outside ANSWER (stray pulse, no effect).
//  Latency: targetValid -> answerSig is 2 cycles (WAIT_TGT->ARM edge, then ARM).
//   postSig -> resultValid is 2 cycles.
//  A tick1Hz arriving in the same cycle as entry to ANSWER or SHOW does not count.
// TESTING
//  T1 reset; startBtn; targetValid with count=3; 3x playerInc; postSig
//     -> answerSig exactly 1 pulse 2 cycles after targetValid; resultCorrect=1; score=1.
//  T2 target=4, 2x playerInc, postSig -> resultCorrect=0, score unchanged,
//     resultValid high for exactly 2 ticks.
//  T3 full game of 5 rounds, all correct -> score=5, roundNum=0, busy=0,
//     no 6th answerSig; startBtn then clears score to 0.
//  T4 ANSWER with no postSig for 8 ticks -> timeoutErr=1, IDLE, busy=0;
//     a later stray postSig has no effect.
//  T5 playerInc and postSig in the same cycle with target=1, 0 prior presses
//     -> guess=1, resultCorrect=1. 300 presses with CW=8 -> guess=255.
//  T6 rstN low in ANSWER with guess=2 -> all outputs 0 next cycle;
//     stray targetValid, postSig and playerInc in IDLE are ignored.

Source files
------------

// File: rtl/round_sequencer.sv
// ============================================================================
// Module  : round_sequencer
// Brief   : Game-round initiator: latches a target, opens the answer window,
//           counts guesses, judges, scores and shows each round's result.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module round_sequencer #(
  parameter int CW           = 8,
  parameter int NUM_ROUNDS   = 5,
  parameter int SHOW_SECS    = 2,
  parameter int TIMEOUT_SECS = 8
) (
  input  logic          Clk100M,
  input  logic          rstN,
  input  logic          tick1Hz,
  input  logic          startBtn,
  input  logic          targetValid,
  input  logic [CW-1:0] targetCount,
  input  logic          playerInc,
  input  logic          postSig,
  output logic          answerSig,
  output logic          busy,
  output logic [CW-1:0] guess,
  output logic [CW-1:0] score,
  output logic [3:0]    roundNum,
  output logic          resultValid,
  output logic          resultCorrect,
  output logic          timeoutErr
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_WAIT_TGT = 3'd1;
  localparam logic [2:0] c_ARM      = 3'd2;
  localparam logic [2:0] c_ANSWER   = 3'd3;
  localparam logic [2:0] c_JUDGE    = 3'd4;
  localparam logic [2:0] c_SHOW     = 3'd5;

  localparam int c_TMAX = (SHOW_SECS > TIMEOUT_SECS) ? SHOW_SECS : TIMEOUT_SECS;
  localparam int c_TW   = $clog2(c_TMAX + 1);

  // Terminal counts compare against the value held before the final tick
  localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_SECS - 1);
  localparam logic [c_TW-1:0] c_SHOW_LAST    = c_TW'(SHOW_SECS - 1);
  localparam logic [3:0]      c_LAST_ROUND   = 4'(NUM_ROUNDS);
  localparam logic [CW-1:0]   c_SAT          = '1;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_TW-1:0] r_ticks;
  logic [CW-1:0]   r_target;
  logic [CW-1:0]   r_guess;
  logic [CW-1:0]   r_score;
  logic [3:0]      r_round;
  logic            r_answer;
  logic            r_busy;
  logic            r_result_valid;
  logic            r_result_correct;
  logic            r_timeout;
  logic            w_timeout_hit;
  logic            w_show_done;

  assign w_timeout_hit = tick1Hz && (r_ticks == c_TIMEOUT_LAST) && !postSig;
  assign w_show_done   = tick1Hz && (r_ticks == c_SHOW_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:     if (startBtn) w_state_nxt = c_WAIT_TGT;
      c_WAIT_TGT: if (targetValid) w_state_nxt = c_ARM;
      c_ARM:      w_state_nxt = c_ANSWER;
      c_ANSWER: begin
        if (postSig)            w_state_nxt = c_JUDGE;
        else if (w_timeout_hit) w_state_nxt = c_IDLE;
      end
      c_JUDGE:    w_state_nxt = c_SHOW;
      c_SHOW: begin
        if (w_show_done)
          w_state_nxt = (r_round == c_LAST_ROUND) ? c_IDLE : c_WAIT_TGT;
      end
      default:    w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (!rstN) begin
      r_state          <= c_IDLE;
      r_ticks          <= '0;
      r_target         <= '0;
      r_guess          <= '0;
      r_score          <= '0;
      r_round          <= '0;
      r_answer         <= 1'b0;
      r_busy           <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_correct <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != c_IDLE);
      r_result_valid <= (w_state_nxt == c_SHOW);
      r_answer       <= (r_state == c_ARM);
      case (r_state)
        c_IDLE: begin
          if (startBtn) begin
            r_score   <= '0;
            r_guess   <= '0;
            r_timeout <= 1'b0;
            r_round   <= 4'd1;
          end
        end
        c_WAIT_TGT: begin
          if (targetValid) begin
            r_target <= targetCount;
            r_guess  <= '0;
          end
        end
        c_ARM: r_ticks <= '0;
        c_ANSWER: begin
          if (playerInc && (r_guess != c_SAT)) r_guess <= r_guess + 1'b1;
          if (tick1Hz) r_ticks <= r_ticks + 1'b1;
          if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_round   <= '0;
          end
        end
        c_JUDGE: begin
          r_result_correct <= (r_guess == r_target);
          if ((r_guess == r_target) && (r_score != c_SAT)) r_score <= r_score + 1'b1;
          r_ticks <= '0;
        end
        c_SHOW: begin
          if (tick1Hz) r_ticks <= r_ticks + 1'b1;
          if (w_show_done)
            r_round <= (r_round == c_LAST_ROUND) ? 4'd0 : r_round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign answerSig     = r_answer;
  assign busy          = r_busy;
  assign guess         = r_guess;
  assign score         = r_score;
  assign roundNum      = r_round;
  assign resultValid   = r_result_valid;
  assign resultCorrect = r_result_correct;
  assign timeoutErr    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_round_sequencer.sv
// ============================================================================
// Module  : tb_round_sequencer
// Brief   : Directed + random stimulus against an in-bench round/score model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_round_sequencer;

  logic       Clk100M = 1'b0;
  logic       rstN = 1'b0;
  logic       tick1Hz = 1'b0;
  logic       startBtn = 1'b0;
  logic       targetValid = 1'b0;
  logic [7:0] targetCount = 8'd0;
  logic       playerInc = 1'b0;
  logic       postSig = 1'b0;
  logic       answerSig, busy, resultValid, resultCorrect, timeoutErr;
  logic [7:0] guess, score;
  logic [3:0] roundNum;

  round_sequencer #(.CW(8), .NUM_ROUNDS(5), .SHOW_SECS(2), .TIMEOUT_SECS(8)) dut (
    .Clk100M(Clk100M), .rstN(rstN), .tick1Hz(tick1Hz), .startBtn(startBtn),
    .targetValid(targetValid), .targetCount(targetCount), .playerInc(playerInc),
    .postSig(postSig), .answerSig(answerSig), .busy(busy), .guess(guess),
    .score(score), .roundNum(roundNum), .resultValid(resultValid),
    .resultCorrect(resultCorrect), .timeoutErr(timeoutErr)
  );

  always #5 Clk100M = ~Clk100M;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: game progress described as phases and second counts
  localparam int P_IDLE = 0, P_WAIT = 1, P_ARM = 2, P_ANS = 3, P_JUDGE = 4, P_SHOW = 5;
  int m_phase = P_IDLE;
  int m_secs = 0, m_guess = 0, m_target = 0, m_score = 0, m_round = 0;
  bit m_answer = 0, m_rc = 0, m_timeout = 0;

  always @(posedge Clk100M) begin
    m_answer = 0;
    if (!rstN) begin
      m_phase = P_IDLE; m_secs = 0; m_guess = 0; m_target = 0;
      m_score = 0; m_round = 0; m_rc = 0; m_timeout = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (startBtn) begin
          m_score = 0; m_guess = 0; m_timeout = 0; m_round = 1; m_phase = P_WAIT;
        end
        P_WAIT: if (targetValid) begin
          m_target = targetCount; m_guess = 0; m_phase = P_ARM;
        end
        P_ARM: begin
          m_answer = 1; m_secs = 0; m_phase = P_ANS;
        end
        P_ANS: begin
          if (playerInc && m_guess < 255) m_guess++;
          if (postSig) m_phase = P_JUDGE;
          else if (tick1Hz) begin
            m_secs++;
            if (m_secs >= 8) begin
              m_timeout = 1; m_round = 0; m_phase = P_IDLE;
            end
          end
        end
        P_JUDGE: begin
          m_rc = (m_guess == m_target);
          if (m_rc && m_score < 255) m_score++;
          m_secs = 0; m_phase = P_SHOW;
        end
        default: if (tick1Hz) begin
          m_secs++;
          if (m_secs == 2) begin
            if (m_round == 5) begin m_round = 0; m_phase = P_IDLE; end
            else begin m_round++; m_phase = P_WAIT; end
          end
        end
      endcase
    end
  end

  int cyc = 0, tv_cyc = 0, ans_cyc = 0, ans_count = 0;

  always @(negedge Clk100M) begin
    cyc++;
    if (targetValid) tv_cyc = cyc;
    if (answerSig === 1'b1) begin ans_cyc = cyc; ans_count++; end
    chk("answerSig",     32'(answerSig),     32'(m_answer));
    chk("busy",          32'(busy),          32'(m_phase != P_IDLE));
    chk("guess",         32'(guess),         32'(m_guess));
    chk("score",         32'(score),         32'(m_score));
    chk("roundNum",      32'(roundNum),      32'(m_round));
    chk("resultValid",   32'(resultValid),   32'(m_phase == P_SHOW));
    chk("resultCorrect", 32'(resultCorrect), 32'(m_rc));
    chk("timeoutErr",    32'(timeoutErr),    32'(m_timeout));
  end

  task automatic drv(input logic s, input logic tv, input logic [7:0] tc,
                     input logic inc, input logic post, input logic tk);
    startBtn = s; targetValid = tv; targetCount = tc;
    playerInc = inc; postSig = post; tick1Hz = tk;
    @(posedge Clk100M); #1;
    startBtn = 0; targetValid = 0; playerInc = 0; postSig = 0; tick1Hz = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 8'd0, 0, 0, 0);
  endtask

  task automatic wait_rv();
    int k = 0;
    while (resultValid !== 1'b1 && k < 10) begin idle(1); k++; end
    chk("wait_resultValid", 32'(resultValid), 32'd1);
  endtask

  // Target, ARM cycle, presses with random gaps, postSig, then wait for SHOW
  task automatic answer(input int tgt, input int presses);
    drv(0, 1, 8'(tgt), 0, 0, 0);
    idle(1);
    for (int i = 0; i < presses; i++) begin
      idle($urandom_range(0, 2));
      drv(0, 0, 8'd0, 1, 0, 0);
    end
    idle($urandom_range(0, 2));
    drv(0, 0, 8'd0, 0, 1, 0);
    wait_rv();
  endtask

  task automatic show_out();
    for (int i = 0; i < 2; i++) begin
      idle($urandom_range(0, 2));
      drv(0, 0, 8'd0, 0, 0, 1);
    end
  endtask

  initial begin
    int t;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_round", 32'(roundNum), 32'd0);
    rstN = 1;
    idle(2);

    // T1: correct round, latency check
    drv(1, 0, 8'd0, 0, 0, 0);
    answer(3, 3);
    chk("t1_correct", 32'(resultCorrect), 32'd1);
    chk("t1_score", 32'(score), 32'd1);
    chk("t1_latency", 32'(ans_cyc - tv_cyc), 32'd2);
    show_out();

    // T2: wrong guess; show held for exactly two ticks
    answer(4, 2);
    chk("t2_correct", 32'(resultCorrect), 32'd0);
    chk("t2_score", 32'(score), 32'd1);
    drv(0, 0, 8'd0, 0, 0, 1);
    chk("t2_rv_after_1tick", 32'(resultValid), 32'd1);
    drv(0, 0, 8'd0, 0, 0, 1);
    chk("t2_rv_after_2tick", 32'(resultValid), 32'd0);
    chk("t2_round", 32'(roundNum), 32'd3);
    for (int r = 3; r <= 5; r++) begin
      t = $urandom_range(0, 5);
      answer(t, $urandom_range(0, 5));
      show_out();
    end
    chk("g1_busy", 32'(busy), 32'd0);

    // T3: full game, all correct
    drv(1, 0, 8'd0, 0, 0, 0);
    ans_count = 0;
    for (int r = 0; r < 5; r++) begin
      t = $urandom_range(0, 6);
      answer(t, t);
      show_out();
    end
    idle(20);
    chk("t3_answers", 32'(ans_count), 32'd5);
    chk("t3_score", 32'(score), 32'd5);
    chk("t3_round", 32'(roundNum), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    drv(1, 0, 8'd0, 0, 0, 0);
    chk("t3_score_clr", 32'(score), 32'd0);
    chk("t3_round1", 32'(roundNum), 32'd1);

    // T4: timeout after eight ticks in ANSWER
    drv(0, 1, 8'd3, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1));
      drv(0, 0, 8'd0, 0, 0, 1);
    end
    chk("t4_timeout", 32'(timeoutErr), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    drv(0, 0, 8'd0, 0, 1, 0);
    idle(2);
    chk("t4_stray_busy", 32'(busy), 32'd0);

    // T5: press coincident with postSig; guess saturation
    drv(1, 0, 8'd0, 0, 0, 0);
    chk("t5_timeout_clr", 32'(timeoutErr), 32'd0);
    drv(0, 1, 8'd1, 0, 0, 0);
    idle(1);
    drv(0, 0, 8'd0, 1, 1, 0);
    wait_rv();
    chk("t5_guess", 32'(guess), 32'd1);
    chk("t5_correct", 32'(resultCorrect), 32'd1);
    show_out();
    drv(0, 1, 8'd0, 0, 0, 0);
    idle(1);
    repeat (300) drv(0, 0, 8'd0, 1, 0, 0);
    chk("t5_sat", 32'(guess), 32'd255);
    drv(0, 0, 8'd0, 0, 1, 0);
    wait_rv();
    chk("t5_wrong", 32'(resultCorrect), 32'd0);
    show_out();

    // T6: reset mid-ANSWER, then stray inputs in IDLE
    drv(0, 1, 8'd5, 0, 0, 0);
    idle(1);
    drv(0, 0, 8'd0, 1, 0, 0);
    drv(0, 0, 8'd0, 1, 0, 0);
    chk("t6_guess2", 32'(guess), 32'd2);
    rstN = 0;
    idle(1);
    rstN = 1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_guess", 32'(guess), 32'd0);
    chk("t6_score", 32'(score), 32'd0);
    chk("t6_answer", 32'(answerSig), 32'd0);
    drv(0, 1, 8'd2, 0, 0, 0);
    drv(0, 0, 8'd0, 0, 1, 0);
    drv(0, 0, 8'd0, 1, 0, 0);
    idle(2);
    chk("t6_stray_busy", 32'(busy), 32'd0);
    chk("t6_stray_guess", 32'(guess), 32'd0);
    chk("t6_no_answer", 32'(answerSig), 32'd0);

    // Random traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      rstN = ($urandom_range(0, 299) != 0);
      drv($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
          8'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0);
    end
    rstN = 1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
